// File: rtl/addr_gen_bp_seq_pkg.sv
// Shared types and elaboration helpers for the LSTM backprop address sequencers.
package lstm_bp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    PH_WR = 1'b0,
    PH_RD = 1'b1
  } phase_t;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 32'd1 : r;
  endfunction

  function automatic bit addr_range_ok(input int unsigned aw, input int unsigned base,
                                       input int unsigned nstep, input int unsigned ncell);
    return (nstep >= 1) && (ncell >= 1) && (aw >= 1) && (aw < 63) &&
           ((longint'(base) + longint'(nstep) * longint'(ncell)) <= (longint'(1) << aw));
  endfunction

endpackage

// File: rtl/addr_gen_bp_seq_cnt_wrap.sv
// Wrapping up-counter with a runtime wrap point bounded by a static maximum.
module cnt_wrap
  import lstm_bp_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] max_dyn,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  assign wrap = inc && ((q == max_dyn) || (q == WIDTH'(MAX)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= wrap ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/addr_gen_bp_seq.sv
// Read/write address sequencer for LSTM backprop buffers, walking cells per phase
// and timesteps forwards or backwards with start/done handshake and stall.
module addr_gen_bp_seq
  import lstm_bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_CELL   = 8,
  parameter int unsigned NUM_STEP   = 4,
  parameter int unsigned DELAY_RD   = 3,
  parameter int unsigned DELAY_WR   = 2,
  parameter bit          RD_FIRST   = 1'b1,
  parameter bit          REVERSE    = 1'b1,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_en,
  input  logic                  i_clr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_rd,
  output logic                  o_we,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned AW      = ADDR_WIDTH;
  localparam int unsigned DLY_MAX = (DELAY_RD > DELAY_WR) ? DELAY_RD : DELAY_WR;
  localparam int unsigned DLY_W   = clog2(DLY_MAX + 1);
  localparam int unsigned CELL_W  = clog2(NUM_CELL);
  localparam int unsigned STEP_W  = clog2(NUM_STEP);
  localparam logic [AW-1:0] FIRST_ADDR =
    AW'(BASE_ADDR + (REVERSE ? (NUM_STEP - 1) * NUM_CELL : 0));
  localparam phase_t FIRST_PH = RD_FIRST ? PH_RD : PH_WR;

  if (!addr_range_ok(ADDR_WIDTH, BASE_ADDR, NUM_STEP, NUM_CELL)) begin : g_range_err
    $fatal(1, "addr_gen_bp_seq: BASE_ADDR + NUM_STEP*NUM_CELL exceeds ADDR_WIDTH range");
  end

  state_t            state;
  phase_t            phase;
  logic [AW-1:0]     addr_q;
  logic [DLY_W-1:0]  dly_q;
  logic [DLY_W-1:0]  delay_cur;
  logic [CELL_W-1:0] cell_q;
  logic [CELL_W-1:0] cell_nxt;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_nxt;
  logic [AW-1:0]     idx_nxt;
  logic [AW-1:0]     addr_nxt;
  logic              adv;
  logic              dly_wrap;
  logic              cell_wrap;
  logic              step_inc;
  logic              step_wrap;

  assign delay_cur = (phase == PH_RD) ? DLY_W'(DELAY_RD) : DLY_W'(DELAY_WR);
  assign adv       = (state == S_RUN) && i_en && !i_clr;
  assign step_inc  = cell_wrap && (phase != FIRST_PH);

  cnt_wrap #(.WIDTH(DLY_W), .MAX(DLY_MAX)) u_dly (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_clr),
    .inc     (adv),
    .max_dyn (delay_cur),
    .q       (dly_q),
    .wrap    (dly_wrap)
  );

  cnt_wrap #(.WIDTH(CELL_W), .MAX(NUM_CELL - 1)) u_cell (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_clr),
    .inc     (dly_wrap),
    .max_dyn (CELL_W'(NUM_CELL - 1)),
    .q       (cell_q),
    .wrap    (cell_wrap)
  );

  cnt_wrap #(.WIDTH(STEP_W), .MAX(NUM_STEP - 1)) u_step (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_clr),
    .inc     (step_inc),
    .max_dyn (STEP_W'(NUM_STEP - 1)),
    .q       (step_q),
    .wrap    (step_wrap)
  );

  // Address is registered from the counters' next values so it lines up with them.
  always_comb begin
    cell_nxt = cell_q;
    step_nxt = step_q;
    if (cell_wrap)     cell_nxt = '0;
    else if (dly_wrap) cell_nxt = cell_q + 1'b1;
    if (step_wrap)     step_nxt = '0;
    else if (step_inc) step_nxt = step_q + 1'b1;
    idx_nxt  = REVERSE ? (AW'(NUM_STEP - 1) - AW'(step_nxt)) : AW'(step_nxt);
    addr_nxt = AW'(BASE_ADDR) + idx_nxt * AW'(NUM_CELL) + AW'(cell_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      phase  <= FIRST_PH;
      addr_q <= FIRST_ADDR;
    end else if (i_clr) begin
      state  <= S_IDLE;
      phase  <= FIRST_PH;
      addr_q <= FIRST_ADDR;
    end else begin
      case (state)
        S_IDLE: if (i_start) state <= S_RUN;
        S_RUN: begin
          if (i_en) begin
            addr_q <= addr_nxt;
            if (cell_wrap) phase <= (phase == PH_RD) ? PH_WR : PH_RD;
            if (step_wrap) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_addr  = addr_q;
  assign o_rd    = (phase == PH_RD);
  assign o_valid = (state == S_RUN);
  assign o_busy  = (state != S_IDLE);
  assign o_done  = (state == S_DONE);
  assign o_we    = (state == S_RUN) && (phase == PH_WR) && (dly_q == delay_cur) && i_en;

endmodule
